// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round controller.
// Holds the FSM state encoding and the round-index helpers.
package sha256_pkg;

  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_MSG_WORDS = 16;
  localparam int RND_W            = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    ROUND    = 3'd2,
    UPDATE   = 3'd3,
    SECOND   = 3'd4,
    DONE     = 3'd5
  } state_e;

  // W(t) comes straight from the message words for the first 16 rounds.
  function automatic logic is_msg_round(input logic [RND_W-1:0] idx);
    return idx < RND_W'(SHA256_MSG_WORDS);
  endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter: synchronous clear, count enable, and a terminal
// flag at ROUNDS-1, where it wraps back to 0.
module sha256_round_cnt
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [RND_W-1:0] cnt,
  output logic             term
);

  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(ROUNDS - 1);

  logic [RND_W-1:0] cnt_q;
  logic [RND_W-1:0] cnt_d;

  assign term = (cnt_q == LAST_IDX);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Control FSM sequencing one SHA-256 compression engine across message blocks.
// Optional SHA256d second pass is enabled by defining SHA256_DOUBLE_HASH_EN.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             blk_valid,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic [RND_W-1:0] k_addr,
  output logic             init_h,
  output logic             load_work,
  output logic             round_en,
  output logic             w_from_msg,
  output logic             update_h,
  output logic             second_pass,
  output logic             busy,
  output logic             digest_valid,
  input  logic             digest_ready
);

  state_e state_q;
  state_e state_d;
  logic   last_q;
  logic   last_d;
  logic   init_h_q;
  logic   init_h_d;
  logic   load_work_q;
  logic   load_work_d;
`ifdef SHA256_DOUBLE_HASH_EN
  logic   pass_q;
  logic   pass_d;
`endif

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_term;
  logic [RND_W-1:0] cnt;

  sha256_round_cnt #(
    .ROUNDS (ROUNDS)
  ) u_round_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .term  (cnt_term)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    init_h_d    = 1'b0;
    load_work_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
`ifdef SHA256_DOUBLE_HASH_EN
    pass_d      = pass_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          init_h_d = 1'b1;
          state_d  = WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        // blk_ready is high throughout this state, so valid alone means accept.
        if (blk_valid) begin
          last_d      = blk_last;
          load_work_d = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        cnt_en = 1'b1;
        if (cnt_term) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (!last_q) begin
          state_d = WAIT_BLK;
        end else begin
`ifdef SHA256_DOUBLE_HASH_EN
          state_d = pass_q ? DONE : SECOND;
`else
          state_d = DONE;
`endif
        end
      end
      SECOND: begin
`ifdef SHA256_DOUBLE_HASH_EN
        pass_d  = 1'b1;
        cnt_clr = 1'b1;
        state_d = ROUND;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (digest_ready) begin
          last_d  = 1'b0;
`ifdef SHA256_DOUBLE_HASH_EN
          pass_d  = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      init_h_q    <= 1'b0;
      load_work_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      init_h_q    <= init_h_d;
      load_work_q <= load_work_d;
    end
  end

`ifdef SHA256_DOUBLE_HASH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end
`endif

  // Moore decode: every output depends only on registered state.
  assign blk_ready    = (state_q == WAIT_BLK);
  assign round_en     = (state_q == ROUND);
  assign update_h     = (state_q == UPDATE);
  assign digest_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign k_addr       = cnt;
  assign w_from_msg   = round_en && is_msg_round(cnt);
  assign load_work    = load_work_q;
`ifdef SHA256_DOUBLE_HASH_EN
  assign second_pass  = (state_q == SECOND);
  assign init_h       = init_h_q || (state_q == SECOND);
`else
  assign second_pass  = 1'b0;
  assign init_h       = init_h_q;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: reset, single/two-block messages,
// mid-round reset, digest stall and ignored inputs during rounds.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       blk_valid;
  logic       blk_last;
  logic       blk_ready;
  logic [5:0] k_addr;
  logic       init_h;
  logic       load_work;
  logic       round_en;
  logic       w_from_msg;
  logic       update_h;
  logic       second_pass;
  logic       busy;
  logic       digest_valid;
  logic       digest_ready;

  logic [14:0] outs;
  assign outs = {blk_ready, k_addr, init_h, load_work, round_en, w_from_msg,
                 update_h, second_pass, busy, digest_valid};

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef SHA256_DOUBLE_HASH_EN
  localparam int EXP_RE = 192;
  localparam int EXP_UH = 3;
  localparam int EXP_SP = 1;
`else
  localparam int EXP_RE = 128;
  localparam int EXP_UH = 2;
  localparam int EXP_SP = 0;
`endif

  always #5 clk = ~clk;

  sha256_round_ctrl #(.ROUNDS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .blk_valid    (blk_valid),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .k_addr       (k_addr),
    .init_h       (init_h),
    .load_work    (load_work),
    .round_en     (round_en),
    .w_from_msg   (w_from_msg),
    .update_h     (update_h),
    .second_pass  (second_pass),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_digest(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (digest_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (outs !== 15'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h want 0000", outs);
    end
    reset = 1'b0;
    tick();
    vec_cnt++;
    if (outs !== 15'd0) begin
      err_cnt++;
      $display("FAIL idle_after_reset: got %h want 0000", outs);
    end
  endtask

  task automatic test_single_block();
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++;
    if (init_h !== 1'b1 || blk_ready !== 1'b1 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL start_to_wait: init_h=%b blk_ready=%b busy=%b want 1 1 1",
               init_h, blk_ready, busy);
    end
    blk_valid = 1'b1;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bit exp_w;
      bit exp_lw;
      exp_w  = (i < 16);
      exp_lw = (i == 0);
      vec_cnt++;
      if (round_en !== 1'b1 || k_addr !== 6'(i) || blk_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL round_seq[%0d]: round_en=%b k_addr=%0d blk_ready=%b want 1 %0d 0",
                 i, round_en, k_addr, blk_ready, i);
      end
      vec_cnt++;
      if (w_from_msg !== exp_w) begin
        err_cnt++;
        $display("FAIL w_from_msg[%0d]: got %b want %b", i, w_from_msg, exp_w);
      end
      vec_cnt++;
      if (load_work !== exp_lw) begin
        err_cnt++;
        $display("FAIL load_work[%0d]: got %b want %b", i, load_work, exp_lw);
      end
      tick();
    end
    vec_cnt++;
    if (update_h !== 1'b1 || round_en !== 1'b0 || k_addr !== 6'd0) begin
      err_cnt++;
      $display("FAIL update_at_T65: update_h=%b round_en=%b k_addr=%0d want 1 0 0",
               update_h, round_en, k_addr);
    end
    tick();
`ifdef SHA256_DOUBLE_HASH_EN
    vec_cnt++;
    if (second_pass !== 1'b1 || init_h !== 1'b1 || round_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL second_pass_pulse: second_pass=%b init_h=%b round_en=%b want 1 1 0",
               second_pass, init_h, round_en);
    end
    tick();
    for (int i = 0; i < 64; i++) begin
      vec_cnt++;
      if (round_en !== 1'b1 || k_addr !== 6'(i)) begin
        err_cnt++;
        $display("FAIL second_round[%0d]: round_en=%b k_addr=%0d", i, round_en, k_addr);
      end
      tick();
    end
    vec_cnt++;
    if (update_h !== 1'b1) begin
      err_cnt++;
      $display("FAIL second_update: got %b want 1", update_h);
    end
    tick();
`endif
    vec_cnt++;
    if (digest_valid !== 1'b1 || blk_ready !== 1'b0 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL digest_at_T66: digest_valid=%b blk_ready=%b busy=%b want 1 0 1",
               digest_valid, blk_ready, busy);
    end
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    vec_cnt++;
    if (outs !== 15'd0) begin
      err_cnt++;
      $display("FAIL back_to_idle: got %h want 0000", outs);
    end
  endtask

  task automatic test_two_block_gap();
    int  lw;
    int  re;
    int  uh;
    int  sp;
    bit  dv_early;
    bit  gap_bad;
    lw = 0; re = 0; uh = 0; sp = 0; dv_early = 1'b0; gap_bad = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    blk_valid = 1'b1;
    blk_last  = 1'b0;
    tick();
    blk_valid = 1'b0;
    for (int i = 0; i < 65; i++) begin
      lw += int'(load_work); re += int'(round_en); uh += int'(update_h); sp += int'(second_pass);
      if (digest_valid) dv_early = 1'b1;
      tick();
    end
    for (int g = 0; g < 5; g++) begin
      if (blk_ready !== 1'b1 || digest_valid !== 1'b0 || round_en !== 1'b0) gap_bad = 1'b1;
      tick();
    end
    vec_cnt++;
    if (gap_bad) begin
      err_cnt++;
      $display("FAIL gap_blk_ready: blk_ready dropped or activity during 5-cycle gap");
    end
    blk_valid = 1'b1;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    for (int i = 0; i < 65; i++) begin
      lw += int'(load_work); re += int'(round_en); uh += int'(update_h); sp += int'(second_pass);
      if (digest_valid) dv_early = 1'b1;
      tick();
    end
`ifdef SHA256_DOUBLE_HASH_EN
    for (int i = 0; i < 66; i++) begin
      lw += int'(load_work); re += int'(round_en); uh += int'(update_h); sp += int'(second_pass);
      if (digest_valid) dv_early = 1'b1;
      tick();
    end
`endif
    vec_cnt++;
    if (lw !== 2 || re !== EXP_RE || uh !== EXP_UH || sp !== EXP_SP) begin
      err_cnt++;
      $display("FAIL two_block_counts: load_work=%0d round_en=%0d update_h=%0d second_pass=%0d want 2 %0d %0d %0d",
               lw, re, uh, sp, EXP_RE, EXP_UH, EXP_SP);
    end
    vec_cnt++;
    if (dv_early || digest_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL two_block_digest: early=%b digest_valid=%b want 0 1", dv_early, digest_valid);
    end
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    start = 1'b1;
    tick();
    start = 1'b0;
    blk_valid = 1'b1;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    vec_cnt++;
    if (k_addr !== 6'd30 || round_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_addr: k_addr=%0d round_en=%b want 30 1", k_addr, round_en);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vec_cnt++;
    if (outs !== 15'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_round: got %h want 0000", outs);
    end
    // Reset beats a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    vec_cnt++;
    if (outs !== 15'd0) begin
      err_cnt++;
      $display("FAIL reset_vs_start: got %h want 0000", outs);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    blk_valid = 1'b1;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    vec_cnt++;
    if (k_addr !== 6'd0 || round_en !== 1'b1 || load_work !== 1'b1) begin
      err_cnt++;
      $display("FAIL restart_first_round: k_addr=%0d round_en=%b load_work=%b want 0 1 1",
               k_addr, round_en, load_work);
    end
    tick();
    vec_cnt++;
    if (k_addr !== 6'd1 || round_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL restart_second_round: k_addr=%0d round_en=%b want 1 1", k_addr, round_en);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_digest_stall();
    bit ok;
    bit stall_bad;
    stall_bad = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    blk_valid = 1'b1;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    wait_digest(ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL stall_reach_done: digest_valid=%b after 400 cycles want 1", digest_valid);
    end
    for (int i = 0; i < 10; i++) begin
      start     = i[0];
      blk_valid = 1'b1;
      tick();
      if (digest_valid !== 1'b1 || blk_ready !== 1'b0 || init_h !== 1'b0 ||
          round_en !== 1'b0) stall_bad = 1'b1;
    end
    start     = 1'b0;
    blk_valid = 1'b0;
    vec_cnt++;
    if (stall_bad) begin
      err_cnt++;
      $display("FAIL digest_stall: digest_valid=%b blk_ready=%b init_h=%b during stall want 1 0 0",
               digest_valid, blk_ready, init_h);
    end
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0 || digest_valid !== 1'b0 || init_h !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_release: busy=%b digest_valid=%b init_h=%b want 0 0 0",
               busy, digest_valid, init_h);
    end
  endtask

  task automatic test_ignore_in_round();
    int rounds;
    int lw;
    bit addr_bad;
    bit ok;
    rounds = 0; lw = 0; addr_bad = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    blk_valid = 1'b1;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (update_h === 1'b1) break;
      if (round_en === 1'b1) begin
        if (k_addr !== 6'(rounds)) addr_bad = 1'b1;
        rounds++;
      end
      lw += int'(load_work);
      start     = (rounds >= 10 && rounds < 14);
      blk_valid = (rounds >= 10 && rounds < 14);
      digest_ready = (rounds >= 20 && rounds < 22);
      tick();
    end
    start = 1'b0;
    blk_valid = 1'b0;
    digest_ready = 1'b0;
    vec_cnt++;
    if (rounds !== 64 || lw !== 1 || addr_bad) begin
      err_cnt++;
      $display("FAIL ignore_in_round: rounds=%0d load_work=%0d addr_bad=%b want 64 1 0",
               rounds, lw, addr_bad);
    end
    wait_digest(ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL ignore_reach_done: digest_valid=%b want 1", digest_valid);
    end
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    vec_cnt++;
    if (outs !== 15'd0) begin
      err_cnt++;
      $display("FAIL ignore_final_idle: got %h want 0000", outs);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    blk_valid    = 1'b0;
    blk_last     = 1'b0;
    digest_ready = 1'b0;
    test_reset();
    test_single_block();
    test_two_block_gap();
    test_reset_mid_round();
    test_digest_stall();
    test_ignore_in_round();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
